// File: rtl/xgmii_link_fault_rs.sv
//------------------------------------------------------------------------------
// xgmii_link_fault_rs : RS link fault detect (64-bit XGMII RX) and TX response.
// Optional macro XGMII_LINK_FAULT_STATS_EN adds fault-entry counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xgmii_link_fault_rs #(
  parameter int SEQ_THRESH     = 4,
  parameter int COL_WINDOW     = 128,
  parameter int TX_OVERRIDE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_block_lock,
  input  logic [63:0] s_xgmii_rxd,
  input  logic [7:0]  s_xgmii_rxc,
  input  logic [63:0] s_xgmii_txd,
  input  logic [7:0]  s_xgmii_txc,
  output logic [63:0] m_xgmii_txd,
  output logic [7:0]  m_xgmii_txc,
  output logic        link_ok,
  output logic        link_fault_local,
  output logic        link_fault_remote
`ifdef XGMII_LINK_FAULT_STATS_EN
  ,
  output logic [15:0] stat_local_fault_cnt,
  output logic [15:0] stat_remote_fault_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_LOCAL  = 2'd1,
    ST_REMOTE = 2'd2
  } state_t;

  typedef struct packed {
    state_t     st;
    logic       last_rem;
    logic [3:0] seq;
    logic [9:0] col;
  } ctx_t;

  localparam logic [3:0]  SEQ_MAX = 4'(SEQ_THRESH);
  localparam logic [9:0]  COL_MAX = 10'(COL_WINDOW);
  localparam logic [63:0] IDLE_D  = 64'h07070707_07070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] RFLT_D  = 64'h0200009C_0200009C;
  localparam logic [7:0]  RFLT_C  = 8'h11;

  state_t      state_q, state_d;
  logic        last_rem_q, last_rem_d;
  logic [3:0]  seq_cnt_q, seq_cnt_d;
  logic [9:0]  col_cnt_q, col_cnt_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        ok_q, loc_q, rem_q;
  ctx_t        ctx_cur, ctx_col0, ctx_col1;

  // One 32-bit column step of the sequence/column counters and state.
  function automatic ctx_t proc_col(input ctx_t c, input logic [31:0] d, input logic [3:0] k);
    ctx_t r;
    logic is_fault;
    logic is_rem;
    r        = c;
    is_rem   = (d[31:24] == 8'h02);
    is_fault = (k == 4'b0001) && (d[7:0] == 8'h9C) && (d[23:8] == 16'h0000) &&
               ((d[31:24] == 8'h01) || is_rem);
    if (is_fault) begin
      if (is_rem == c.last_rem) begin
        if (c.seq < SEQ_MAX) r.seq = c.seq + 4'd1;
      end else begin
        r.last_rem = is_rem;
        r.seq      = 4'd1;
      end
      r.col = 10'd0;
      if (r.seq >= SEQ_MAX) r.st = is_rem ? ST_REMOTE : ST_LOCAL;
    end else begin
      if (c.col < COL_MAX) r.col = c.col + 10'd1;
      if (r.col == COL_MAX) begin
        r.seq = 4'd0;
        r.st  = ST_OK;
      end
    end
    return r;
  endfunction

  always_comb begin
    ctx_cur  = {state_q, last_rem_q, seq_cnt_q, col_cnt_q};
    ctx_col0 = proc_col(ctx_cur, s_xgmii_rxd[31:0], s_xgmii_rxc[3:0]);
    ctx_col1 = proc_col(ctx_col0, s_xgmii_rxd[63:32], s_xgmii_rxc[7:4]);
    state_d    = ctx_col1.st;
    last_rem_d = ctx_col1.last_rem;
    seq_cnt_d  = ctx_col1.seq;
    col_cnt_d  = ctx_col1.col;
    // Loss of block lock forces a fully-qualified local fault this cycle.
    if (!rx_block_lock) begin
      state_d    = ST_LOCAL;
      last_rem_d = 1'b0;
      seq_cnt_d  = SEQ_MAX;
      col_cnt_d  = 10'd0;
    end
  end

  always_comb begin
    txd_d = s_xgmii_txd;
    txc_d = s_xgmii_txc;
    if (TX_OVERRIDE_EN != 0) begin
      if (state_d == ST_LOCAL) begin
        txd_d = RFLT_D;
        txc_d = RFLT_C;
      end else if (state_d == ST_REMOTE) begin
        txd_d = IDLE_D;
        txc_d = IDLE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOCAL;
      last_rem_q <= 1'b0;
      seq_cnt_q  <= 4'd0;
      col_cnt_q  <= 10'd0;
      txd_q      <= IDLE_D;
      txc_q      <= IDLE_C;
      ok_q       <= 1'b0;
      loc_q      <= 1'b1;
      rem_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_rem_q <= last_rem_d;
      seq_cnt_q  <= seq_cnt_d;
      col_cnt_q  <= col_cnt_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      ok_q       <= (state_d == ST_OK);
      loc_q      <= (state_d == ST_LOCAL);
      rem_q      <= (state_d == ST_REMOTE);
    end
  end

  assign m_xgmii_txd       = txd_q;
  assign m_xgmii_txc       = txc_q;
  assign link_ok           = ok_q;
  assign link_fault_local  = loc_q;
  assign link_fault_remote = rem_q;

`ifdef XGMII_LINK_FAULT_STATS_EN
  logic [15:0] stat_loc_q;
  logic [15:0] stat_rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loc_q <= 16'd0;
      stat_rem_q <= 16'd0;
    end else begin
      if ((state_d == ST_LOCAL) && (state_q != ST_LOCAL) && (stat_loc_q != 16'hFFFF))
        stat_loc_q <= stat_loc_q + 16'd1;
      if ((state_d == ST_REMOTE) && (state_q != ST_REMOTE) && (stat_rem_q != 16'hFFFF))
        stat_rem_q <= stat_rem_q + 16'd1;
    end
  end

  assign stat_local_fault_cnt  = stat_loc_q;
  assign stat_remote_fault_cnt = stat_rem_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xgmii_link_fault_rs.sv
//------------------------------------------------------------------------------
// tb_xgmii_link_fault_rs : directed scoreboard bench for xgmii_link_fault_rs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_xgmii_link_fault_rs;

  localparam logic [63:0] IDLE_D = 64'h07070707_07070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] LOC2_D = 64'h0100009C_0100009C;
  localparam logic [63:0] REM2_D = 64'h0200009C_0200009C;
  localparam logic [63:0] ALT_D  = 64'h0200009C_0100009C;
  localparam logic [63:0] REM0_D = 64'h07070707_0200009C;
  localparam logic [7:0]  REM0_C = 8'hF1;
  localparam logic [7:0]  SEQ_C  = 8'h11;
  localparam logic [1:0]  E_OK   = 2'd0;
  localparam logic [1:0]  E_LOC  = 2'd1;
  localparam logic [1:0]  E_REM  = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_block_lock = 1'b1;
  logic [63:0] s_xgmii_rxd = IDLE_D;
  logic [7:0]  s_xgmii_rxc = IDLE_C;
  logic [63:0] s_xgmii_txd = 64'd0;
  logic [7:0]  s_xgmii_txc = 8'd0;
  logic [63:0] m_xgmii_txd;
  logic [7:0]  m_xgmii_txc;
  logic        link_ok, link_fault_local, link_fault_remote;
`ifdef XGMII_LINK_FAULT_STATS_EN
  logic [15:0] stat_local_fault_cnt, stat_remote_fault_cnt;
`endif

  xgmii_link_fault_rs dut (
    .clk               (clk),
    .rst               (rst),
    .rx_block_lock     (rx_block_lock),
    .s_xgmii_rxd       (s_xgmii_rxd),
    .s_xgmii_rxc       (s_xgmii_rxc),
    .s_xgmii_txd       (s_xgmii_txd),
    .s_xgmii_txc       (s_xgmii_txc),
    .m_xgmii_txd       (m_xgmii_txd),
    .m_xgmii_txc       (m_xgmii_txc),
    .link_ok           (link_ok),
    .link_fault_local  (link_fault_local),
    .link_fault_remote (link_fault_remote)
`ifdef XGMII_LINK_FAULT_STATS_EN
    ,
    .stat_local_fault_cnt  (stat_local_fault_cnt),
    .stat_remote_fault_cnt (stat_remote_fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the output expected after the next edge.
  task automatic cyc(input logic [63:0] rxd, input logic [7:0] rxc, input logic lock,
                     input logic [1:0] exp_st, input string name);
    exp_t        e;
    logic [63:0] td;
    logic [7:0]  tc;
    td = {16'hDA7A, n_cyc[15:0], ~n_cyc[15:0], 16'h55AA};
    tc = n_cyc[7:0];
    s_xgmii_rxd   = rxd;
    s_xgmii_rxc   = rxc;
    rx_block_lock = lock;
    s_xgmii_txd   = td;
    s_xgmii_txc   = tc;
    e.name = name;
    case (exp_st)
      E_OK:    begin e.txd = td;     e.txc = tc;     e.st = 3'b100; end
      E_LOC:   begin e.txd = REM2_D; e.txc = SEQ_C;  e.st = 3'b010; end
      default: begin e.txd = IDLE_D; e.txc = IDLE_C; e.st = 3'b001; end
    endcase
    sb.push_back(e);
    n_cyc++;
    @(posedge clk);
    #2;
  endtask

  // n idle cycles; the state clears to OK on the last one.
  task automatic idles_clear(input int n, input logic [1:0] st_before, input string name);
    for (int i = 0; i < n; i++)
      cyc(IDLE_D, IDLE_C, 1'b1, (i == n - 1) ? E_OK : st_before, name);
  endtask

  task automatic idles(input int n, input logic [1:0] st, input string name);
    for (int i = 0; i < n; i++) cyc(IDLE_D, IDLE_C, 1'b1, st, name);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge clk);
        check({e.name, " tx"}, {m_xgmii_txc, m_xgmii_txd}, {e.txc, e.txd});
        check({e.name, " status"}, {69'd0, link_ok, link_fault_local, link_fault_remote},
              {69'd0, e.st});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset tx", {m_xgmii_txc, m_xgmii_txd}, {IDLE_C, IDLE_D});
    check("reset status", {69'd0, link_ok, link_fault_local, link_fault_remote}, {69'd0, 3'b010});
    @(posedge clk);
    #2 rst = 1'b0;

    // 128 clean columns take 64 cycles to clear the power-up LOCAL state.
    idles_clear(64, E_LOC, "powerup");
    idles(3, E_OK, "passthru");

    // Four local columns over two cycles.
    cyc(LOC2_D, SEQ_C, 1'b1, E_OK, "local-a");
    cyc(LOC2_D, SEQ_C, 1'b1, E_LOC, "local-b");
    idles_clear(64, E_LOC, "local-clear");

    // Four remote columns 100 columns apart accumulate.
    for (int r = 0; r < 4; r++) begin
      cyc(REM0_D, REM0_C, 1'b1, (r == 3) ? E_REM : E_OK, "remote-seq");
      if (r < 3) idles(49, E_OK, "remote-gap");
    end
    idles_clear(64, E_REM, "remote-clear");

    // Alternating types never build a sequence.
    for (int i = 0; i < 8; i++) cyc(ALT_D, SEQ_C, 1'b1, E_OK, "alternate");
    // Remote columns separated by more than the window never accumulate.
    for (int r = 0; r < 4; r++) begin
      idles(65, E_OK, "sparse-gap");
      cyc(REM0_D, REM0_C, 1'b1, E_OK, "sparse-remote");
    end

    cyc(IDLE_D, IDLE_C, 1'b0, E_LOC, "lock-drop");
    idles_clear(64, E_LOC, "lock-clear");
`ifdef XGMII_LINK_FAULT_STATS_EN
    // Second LOCAL entry of the run (first was local-b); one REMOTE entry so far.
    check("stat local", {56'd0, stat_local_fault_cnt}, {56'd0, 16'd2});
    check("stat remote", {56'd0, stat_remote_fault_cnt}, {56'd0, 16'd1});
`endif

    cyc(REM2_D, SEQ_C, 1'b1, E_OK, "remote2-a");
    cyc(REM2_D, SEQ_C, 1'b1, E_REM, "remote2-b");
    cyc(IDLE_D, IDLE_C, 1'b1, E_REM, "remote-hold");

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset tx", {m_xgmii_txc, m_xgmii_txd}, {IDLE_C, IDLE_D});
    check("async reset status", {69'd0, link_ok, link_fault_local, link_fault_remote},
          {69'd0, 3'b010});
`ifdef XGMII_LINK_FAULT_STATS_EN
    check("async reset stats", {40'd0, stat_local_fault_cnt, stat_remote_fault_cnt}, 72'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idles(2, E_LOC, "post-reset");

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard drained", 72'(sb.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
